// File: rtl/mul_sequencer.sv
// mul_sequencer: HI/LO instruction controller for a shift-add multiplier datapath.
// Latches operands, issues STEPS step strobes, then captures the product into HI/LO.
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32,
    parameter int CNTW  = 6
) (
    input  logic               clk,
    input  logic               firstart,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         signal,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    output logic               dp_load,
    output logic               dp_step,
    output logic [WIDTH-1:0]   dp_a,
    output logic [WIDTH-1:0]   dp_b,
    input  logic [2*WIDTH-1:0] dp_product,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data
);
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, WRITE} state_t;
    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d, rd_q, rd_d;
    logic              rv_q, rv_d, done_q, done_d;
    logic              accept;
    // Ready is held low while reset is asserted so nothing is accepted at release.
    assign req_ready = (state_q == IDLE) && !firstart;
    assign accept    = req_valid && req_ready;
    assign dp_load   = state_q == LOAD;
    assign dp_step   = state_q == RUN;
    assign busy      = state_q != IDLE;
    assign dp_a      = a_q;
    assign dp_b      = b_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rd_data   = rd_q;
    assign rd_valid  = rv_q;
    assign done      = done_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        rv_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                case (signal)
                    F_MULTU: begin
                        a_d     = data_a;
                        b_d     = data_b;
                        state_d = LOAD;
                    end
                    F_MFHI: begin
                        rd_d = hi_q;
                        rv_d = 1'b1;
                    end
                    F_MFLO: begin
                        rd_d = lo_q;
                        rv_d = 1'b1;
                    end
                    F_MTHI: hi_d = data_a;
                    F_MTLO: lo_d = data_a;
                    default: ;
                endcase
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d   = cnt_q + CNTW'(1);
                state_d = (cnt_q == CNTW'(STEPS - 1)) ? WRITE : RUN;
            end
            WRITE: begin
                {hi_d, lo_d} = dp_product;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge firstart) begin
        if (firstart) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Controller for the shift-add multiplier datapath used by the ALU stage.
- Accepts HI/LO-class instructions (MULTU, MFHI, MFLO, MTHI, MTLO) from the pipeline. Loads operands into the datapath and issues exactly STEPS step strobes. Captures the 64-bit product into architectural HI/LO registers.
- Stalls the pipeline, through req_ready, while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- STEPS, 32, number of step strobes per multiply; must be ≤ 2^CNTW.
- CNTW, 6, step counter width.

Ports:
- clk  input  1  clock; all controller state changes on posedge.
- firstart  input  1  reset, asynchronous, active-high.
- req_valid  input  1  instruction request present.
- req_ready  output  1  controller can accept a request; high only in IDLE.
- signal  input  6  funct code: 25 MULTU, 16 MFHI, 18 MFLO, 17 MTHI, 19 MTLO.
- data_a  input  WIDTH  multiplicand / MTHI-MTLO source.
- data_b  input  WIDTH  multiplier.
- dp_load  output  1  one-cycle pulse: datapath loads dp_a/dp_b and clears its accumulator.
- dp_step  output  1  one shift-add step per cycle while high; datapath samples it on negedge of the same cycle.
- dp_a  output  WIDTH  latched multiplicand.
- dp_b  output  WIDTH  latched multiplier.
- dp_product  input  2*WIDTH  datapath accumulator.
- busy  output  1  multiply in flight (state ≠ IDLE).
- done  output  1  one-cycle pulse: HI/LO just updated by a multiply.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- rd_valid  output  1  one-cycle pulse: rd_data valid.
- rd_data  output  WIDTH  MFHI/MFLO result.

Behaviour:
- Reset (firstart=1, async):
  - State returns to IDLE and the counter is cleared.
  - hi, lo, dp_a, dp_b and rd_data are 0.
  - dp_load, dp_step, busy, done and rd_valid are 0. req_ready is 1 once firstart is released.
  - A multiply in progress is aborted immediately; dp_step drops without waiting for a clock edge, and HI/LO are not written.
- Handshake: a request is accepted on a posedge with req_valid && req_ready. signal, data_a and data_b are sampled at that edge only.
- States:
  - IDLE: req_ready=1. On accepting MULTU, latch dp_a=data_a and dp_b=data_b, then go to LOAD.
  - LOAD: dp_load=1 for exactly one cycle, counter cleared, then go to RUN.
  - RUN: dp_step=1 each cycle and the counter increments. When counter==STEPS-1, go to WRITE. RUN lasts exactly STEPS cycles.
  - WRITE: dp_step=0. At the closing edge, {hi,lo} is set to dp_product, done is 1 for the following cycle, and the state returns to IDLE.
- Latency (STEPS=32), measured from the accept edge E0:
  - dp_load is high during E0–E1.
  - dp_step is high during E1–E33.
  - HI/LO are updated and done rises at E34, i.e. STEPS+2 edges after accept.
  - The next accept is possible at E35.
- Non-multiply requests (accepted only in IDLE):
  - MFHI/MFLO: rd_data=hi or lo and rd_valid=1 in the cycle after accept. Otherwise rd_valid=0 and rd_data holds its last value.
  - MTHI/MTLO: hi or lo is set to data_a at the accept edge; no other outputs change.
  - Any other funct: accepted and ignored; no state, HI/LO or pulse change.
- Stall: while busy, req_ready=0. MFHI/MFLO issued during a multiply wait, and then read the new product.
- done and a request accepted at the same edge: allowed. At E35, done=1 and the new request is being accepted. An MFHI accepted at E35 returns the new HI.
- Arithmetic is unsigned. No overflow is detected; the full 2*WIDTH product is stored.
- dp_a and dp_b hold their values until the next MULTU accept.

Test Plan:
- Reset, then MULTU a=7, b=6 against a shift-add datapath model → dp_load is a 1-cycle pulse, dp_step has exactly 32 cycles high, done rises at E34, hi=0, lo=42.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MFHI → rd_valid pulse with rd_data=0xFFFFFFFE; MFLO → rd_data=0x00000001.
- Hold MFLO on req_valid during a multiply (a=3, b=5) → req_ready stays 0 until done. The read is accepted at E35 and rd_data=15.
- MTHI data_a=0xA5A5A5A5, then MTLO data_a=0x12345678 → hi/lo equal those values; busy, done and dp_load stay 0.
- Assert firstart asynchronously mid-RUN (step 10) → dp_step, busy and done fall with no clock edge, hi=lo=0. A new MULTU 2×3 afterwards gives lo=6.
- Issue funct 6'd32 → accepted, no output change. Back-to-back MULTU requests → second accepted at E35 and its done at E35+34.
